write_back_stage_param: RTL and testbench

// - Parametrised successor of the RV32I write-back stage: owns the MEM/WB pipeline register, load extraction and the result select.
// - Adds stall/flush control, byte/half load alignment with sign/zero extension, and a 4-way result mux (ALU, load, PC+4, immediate).
// - Sits between the memory stage and the register file.
// - Drives the register-file write port and the WB forwarding path to the hazard unit.

---
 rtl/write_back_stage_param.sv | 130 +++++++++++++
 tb/tb_write_back_stage_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage_param.sv
// RV32I/RV64I write-back stage: MEM/WB register, load alignment/extension and result select.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module write_back_stage_param #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  stall_w,
    input  logic                  flush_w,
    input  logic                  valid_m,
    input  logic                  reg_write_m,
    input  logic [1:0]            result_src_m,
    input  logic [2:0]            load_type_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [XLEN-1:0]       alu_result_m,
    input  logic [XLEN-1:0]       read_data_m,
    input  logic [XLEN-1:0]       pc_plus4_m,
    input  logic [XLEN-1:0]       imm_ext_m,
    output logic                  reg_write_w_out,
    output logic [REG_ADDR_W-1:0] rd_w_out,
    output logic [XLEN-1:0]       result_w,
    output logic                  valid_w,
    output logic                  retire_w,
    output logic [CNT_W-1:0]      retire_cnt
);

    logic                  valid_q;
    logic                  reg_write_q;
    logic [1:0]            result_src_q;
    logic [2:0]            load_type_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       read_data_q;
    logic [XLEN-1:0]       pc_plus4_q;
    logic [XLEN-1:0]       imm_q;

    logic [31:0]           load_word;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [XLEN-1:0]       load_val;

    // Control bits: a flush turns the slot into a bubble and wins over a stall.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush_w) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (!stall_w) begin
            valid_q     <= valid_m;
            reg_write_q <= reg_write_m;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            result_src_q <= '0;
            load_type_q  <= '0;
            rd_q         <= '0;
            alu_q        <= '0;
            read_data_q  <= '0;
            pc_plus4_q   <= '0;
            imm_q        <= '0;
        end else if (flush_w || !stall_w) begin
            result_src_q <= result_src_m;
            load_type_q  <= load_type_m;
            rd_q         <= rd_m;
            alu_q        <= alu_result_m;
            read_data_q  <= read_data_m;
            pc_plus4_q   <= pc_plus4_m;
            imm_q        <= imm_ext_m;
        end
    end

    // Only the low word of memory data is ever used; halfword picks ignore addr[0].
    always_comb begin
        load_word = read_data_q[31:0];
        load_half = alu_q[1] ? load_word[31:16] : load_word[15:0];
        case (alu_q[1:0])
            2'b00:   load_byte = load_word[7:0];
            2'b01:   load_byte = load_word[15:8];
            2'b10:   load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        case (load_type_q)
            3'b000:  load_val = XLEN'($signed(load_byte));
            3'b001:  load_val = XLEN'($signed(load_half));
            3'b100:  load_val = XLEN'(load_byte);
            3'b101:  load_val = XLEN'(load_half);
            default: load_val = XLEN'($signed(load_word));
        endcase
    end

    always_comb begin
        case (result_src_q)
            2'b00:   result_w = alu_q;
            2'b01:   result_w = load_val;
            2'b10:   result_w = pc_plus4_q;
            default: result_w = imm_q;
        endcase
    end

    assign valid_w         = valid_q;
    assign rd_w_out        = rd_q;
    assign reg_write_w_out = valid_q & reg_write_q & (rd_q != '0);

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q;

    // An instruction retires on the cycle it leaves WB, so a stall delays the pulse.
    assign retire_w = valid_q & ~stall_w;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            retire_cnt_q <= '0;
        end else if (retire_w) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_w   = 1'b0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_write_back_stage_param.sv
// Scoreboard bench for write_back_stage_param; expected W-stage contents are queued at drive time.
// Counter checks follow WB_RETIRE_CNT_EN (bench uses a 4-bit counter so wrap is reachable).
module tb_write_back_stage_param;

    localparam int XLEN  = 32;
    localparam int RW    = 5;
    localparam int CNT_W = 4;

    logic            clk = 1'b0;
    logic            srst;
    logic            stall_w, flush_w, valid_m, reg_write_m;
    logic [1:0]      result_src_m;
    logic [2:0]      load_type_m;
    logic [RW-1:0]   rd_m;
    logic [XLEN-1:0] alu_result_m, read_data_m, pc_plus4_m, imm_ext_m;
    logic            reg_write_w_out, valid_w, retire_w;
    logic [RW-1:0]   rd_w_out;
    logic [XLEN-1:0] result_w;
    logic [CNT_W-1:0] retire_cnt;

    typedef struct {
        logic        valid;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t     exp_q[$];
    wb_exp_t     cur;
    logic [CNT_W-1:0] exp_cnt;
    int          assert_count = 0;
    int          fail_count   = 0;
    int          pulse_count;

    write_back_stage_param #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CNT_W)) dut (
        .clk(clk), .srst(srst), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
        .load_type_m(load_type_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
        .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m), .imm_ext_m(imm_ext_m),
        .reg_write_w_out(reg_write_w_out), .rd_w_out(rd_w_out), .result_w(result_w),
        .valid_w(valid_w), .retire_w(retire_w), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one M-stage slot, check the retire pulse for the instruction currently in W,
    // then after the edge compare W against the scoreboard head.
    task automatic applyStimulus(input logic v, input logic we, input logic [1:0] src,
                                 input logic [2:0] lt, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] rdata,
                                 input logic [31:0] pc4, input logic [31:0] imm,
                                 input logic st, input logic fl, input logic [31:0] exp_res,
                                 input string tag);
        wb_exp_t e;
        logic    exp_ret;
        valid_m = v; reg_write_m = we; result_src_m = src; load_type_m = lt; rd_m = rd;
        alu_result_m = alu; read_data_m = rdata; pc_plus4_m = pc4; imm_ext_m = imm;
        stall_w = st; flush_w = fl;
        if (fl)      e = '{1'b0, 1'b0, rd, exp_res, 1'b0};
        else if (st) e = cur;
        else         e = '{v, v & we & (rd != 5'd0), rd, exp_res, 1'b1};
        exp_q.push_back(e);
`ifdef WB_RETIRE_CNT_EN
        exp_ret = cur.valid & ~st;
`else
        exp_ret = 1'b0;
`endif
        #1;
        checkOutput({tag, ".retire_w"}, 64'(retire_w), 64'(exp_ret));
        if (retire_w) pulse_count++;
        if (exp_ret) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
        cur = exp_q.pop_front();
        checkOutput({tag, ".valid_w"}, 64'(valid_w), 64'(cur.valid));
        checkOutput({tag, ".reg_write"}, 64'(reg_write_w_out), 64'(cur.we));
        if (cur.chk_data) begin
            checkOutput({tag, ".rd_w"}, 64'(rd_w_out), 64'(cur.rd));
            checkOutput({tag, ".result_w"}, 64'(result_w), 64'(cur.res));
        end
        checkOutput({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(exp_cnt));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".valid_w"}, 64'(valid_w), 64'd0);
        checkOutput({tag, ".reg_write"}, 64'(reg_write_w_out), 64'd0);
        checkOutput({tag, ".rd_w"}, 64'(rd_w_out), 64'd0);
        checkOutput({tag, ".result_w"}, 64'(result_w), 64'd0);
        checkOutput({tag, ".retire_w"}, 64'(retire_w), 64'd0);
        checkOutput({tag, ".retire_cnt"}, 64'(retire_cnt), 64'd0);
        cur = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b1};
        exp_cnt = '0;
        exp_q.delete();
    endtask

    localparam logic [31:0] RDATA = 32'h80FF7F01;

    initial begin
        int pulses_expected;
        logic [CNT_W-1:0] cnt_before;
        srst = 1'b1; stall_w = 0; flush_w = 0; valid_m = 0; reg_write_m = 0;
        result_src_m = 0; load_type_m = 0; rd_m = 0; alu_result_m = 0;
        read_data_m = 0; pc_plus4_m = 0; imm_ext_m = 0;
        pulse_count = 0;
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        @(negedge clk);
        srst = 1'b0;

        applyStimulus(1, 1, 2'b00, 3'b010, 5, 32'h1234, 0, 0, 0, 0, 0, 32'h1234, "alu");
        applyStimulus(1, 1, 2'b01, 3'b000, 6, 32'h1003, RDATA, 0, 0, 0, 0, 32'hFFFFFF80, "lb3");
        applyStimulus(1, 1, 2'b01, 3'b100, 6, 32'h1001, RDATA, 0, 0, 0, 0, 32'h0000007F, "lbu1");
        applyStimulus(1, 1, 2'b01, 3'b001, 6, 32'h1002, RDATA, 0, 0, 0, 0, 32'hFFFF80FF, "lh2");
        applyStimulus(1, 1, 2'b01, 3'b101, 6, 32'h1000, RDATA, 0, 0, 0, 0, 32'h00007F01, "lhu0");
        applyStimulus(1, 1, 2'b01, 3'b010, 6, 32'h1002, RDATA, 0, 0, 0, 0, 32'h80FF7F01, "lw");
        applyStimulus(1, 1, 2'b01, 3'b011, 6, 32'h1001, RDATA, 0, 0, 0, 0, 32'h80FF7F01, "ldundef");
        applyStimulus(1, 1, 2'b01, 3'b001, 6, 32'h1003, RDATA, 0, 0, 0, 0, 32'hFFFF80FF, "lhodd");
        applyStimulus(1, 1, 2'b01, 3'b000, 6, 32'h1000, RDATA, 0, 0, 0, 0, 32'h00000001, "lb0");
        applyStimulus(1, 1, 2'b00, 3'b010, 0, 32'h55, 0, 0, 0, 0, 0, 32'h55, "x0");
        applyStimulus(1, 1, 2'b11, 3'b010, 9, 32'h1, 0, 32'h8, 32'hABCDE000, 0, 0, 32'hABCDE000, "imm");
        applyStimulus(1, 1, 2'b10, 3'b010, 10, 32'h1, 0, 32'h104, 32'h7, 0, 0, 32'h104, "pc4");
        applyStimulus(0, 1, 2'b00, 3'b010, 11, 32'h99, 0, 0, 0, 0, 0, 32'h99, "bubble");

        // Three stalled cycles offering a different instruction must leave W untouched.
        applyStimulus(1, 1, 2'b00, 3'b010, 7, 32'h77, 0, 0, 0, 0, 0, 32'h77, "preStall");
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1, 2'b00, 3'b010, 12, 32'hDEAD, 0, 0, 0, 1, 0, 32'h0, "stall");
        applyStimulus(1, 1, 2'b00, 3'b010, 12, 32'hBEEF, 0, 0, 0, 1, 1, 32'h0, "stallFlush");
        applyStimulus(1, 1, 2'b00, 3'b010, 13, 32'h13, 0, 0, 0, 0, 1, 32'h0, "flush");

        // Four instructions, the second held for two stall cycles, then drained.
        applyStimulus(0, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0, 0, 32'h0, "drain");
        pulse_count = 0;
        cnt_before = retire_cnt;
        applyStimulus(1, 1, 2'b00, 3'b010, 1, 32'hA1, 0, 0, 0, 0, 0, 32'hA1, "i1");
        applyStimulus(1, 1, 2'b00, 3'b010, 2, 32'hA2, 0, 0, 0, 0, 0, 32'hA2, "i2");
        applyStimulus(1, 1, 2'b00, 3'b010, 3, 32'hA3, 0, 0, 0, 1, 0, 32'h0, "i2stall");
        applyStimulus(1, 1, 2'b00, 3'b010, 3, 32'hA3, 0, 0, 0, 1, 0, 32'h0, "i2stall");
        applyStimulus(1, 1, 2'b00, 3'b010, 3, 32'hA3, 0, 0, 0, 0, 0, 32'hA3, "i3");
        applyStimulus(1, 1, 2'b00, 3'b010, 4, 32'hA4, 0, 0, 0, 0, 0, 32'hA4, "i4");
        applyStimulus(0, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0, 0, 32'h0, "tail");
`ifdef WB_RETIRE_CNT_EN
        pulses_expected = 4;
`else
        pulses_expected = 0;
`endif
        checkOutput("retirePulses", 64'(pulse_count), 64'(pulses_expected));
        checkOutput("retireDelta", 64'(CNT_W'(retire_cnt - cnt_before)), 64'(pulses_expected));

        // Asynchronous reset in the middle of a cycle with a valid instruction in W.
        applyStimulus(1, 1, 2'b00, 3'b010, 8, 32'h88, 0, 0, 0, 0, 0, 32'h88, "preReset");
        #2;
        srst = 1'b1;
        #1;
        checkReset("midReset");
        @(negedge clk);
        srst = 1'b0;
        applyStimulus(0, 1, 2'b00, 3'b010, 5, 32'h0, 0, 0, 0, 0, 0, 32'h0, "postReset");

        // 2^CNT_W retirements from a fresh count must wrap back to zero.
        for (int i = 0; i < (1 << CNT_W); i++)
            applyStimulus(1, 1, 2'b00, 3'b010, 5'(i + 1), 32'(i), 0, 0, 0, 0, 0, 32'(i), "wrap");
        applyStimulus(0, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0, 0, 32'h0, "wrapEnd");
        checkOutput("wrapZero", 64'(retire_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
